// File: rtl/tlul_a_arbiter_if.sv
// Bundle of TL-UL A- and D-channel signals for N parallel lanes.
// Multi-lane payloads are flattened: lane i occupies [i*W +: W].
//   modport master : drives A requests and D ready; receives A ready and D beats
//   modport slave  : receives A requests and D ready; drives A ready and D beats
interface tlul_a_arbiter_if #(
  parameter int N            = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 2,
  parameter int SINK_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH/8
);
  logic [N-1:0]              a_valid;
  logic [N-1:0]              a_ready;
  logic [N*OPCODE_WIDTH-1:0] a_opcode;
  logic [N*PARAM_WIDTH-1:0]  a_param;
  logic [N*SIZE_WIDTH-1:0]   a_size;
  logic [N*SRC_WIDTH-1:0]    a_source;
  logic [N*ADDR_WIDTH-1:0]   a_address;
  logic [N*MASK_WIDTH-1:0]   a_mask;
  logic [N*DATA_WIDTH-1:0]   a_data;

  logic [N-1:0]              d_valid;
  logic [N-1:0]              d_ready;
  logic [N*OPCODE_WIDTH-1:0] d_opcode;
  logic [N*PARAM_WIDTH-1:0]  d_param;
  logic [N*SIZE_WIDTH-1:0]   d_size;
  logic [N*SRC_WIDTH-1:0]    d_source;
  logic [N*SINK_WIDTH-1:0]   d_sink;
  logic [N*DATA_WIDTH-1:0]   d_data;
  logic [N-1:0]              d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );
endinterface

// File: rtl/tlul_a_arbiter.sv
// Round-robin TL-UL arbiter: NUM_MASTERS requesters share one slave port.
// One A request at a time is captured into a registered output stage and sent
// with the master index as source; D beats are routed back by source with the
// master's original source ID restored. One outstanding request per master.
// Ports:
//   clk_100, reset_n : clock, asynchronous active-low reset
//   mst              : per-master A/D lanes (arbiter is the slave side)
//   slv              : single slave A/D lane (arbiter is the master side)
//   d_unexpected     : one-cycle pulse after an unroutable D beat was dropped
module tlul_a_arbiter #(
  parameter int NUM_MASTERS  = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 2,
  parameter int SINK_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH/8
) (
  input  logic              clk_100,
  input  logic              reset_n,
  tlul_a_arbiter_if.slave   mst,
  tlul_a_arbiter_if.master  slv,
  output logic              d_unexpected
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  pending_q, pending_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [SRC_WIDTH-1:0]    src_tbl_q [NUM_MASTERS];
  logic [SRC_WIDTH-1:0]    src_tbl_d [NUM_MASTERS];
  logic [OPCODE_WIDTH-1:0] a_opcode_q, a_opcode_d;
  logic [PARAM_WIDTH-1:0]  a_param_q, a_param_d;
  logic [SIZE_WIDTH-1:0]   a_size_q, a_size_d;
  logic [SRC_WIDTH-1:0]    a_source_q, a_source_d;
  logic [ADDR_WIDTH-1:0]   a_address_q, a_address_d;
  logic [MASK_WIDTH-1:0]   a_mask_q, a_mask_d;
  logic [DATA_WIDTH-1:0]   a_data_q, a_data_d;
  logic                    d_unexpected_q, d_unexpected_d;

  logic [NUM_MASTERS-1:0]  eligible;
  logic                    found;
  logic [GW-1:0]           winner;
  logic                    a_hs;
  logic                    d_routed;
  logic [GW-1:0]           d_sel;
  logic                    d_hs;

  assign eligible = mst.a_valid & ~pending_q;

  // Round-robin search starting just after the last granted master.
  always_comb begin
    int cand;
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = (int'(last_grant_q) + 1 + k) % NUM_MASTERS;
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = GW'(cand);
      end
    end
  end

  // A winner only exists when it is valid, so ready implies the handshake.
  assign a_hs = (state_q == IDLE) && found;

  always_comb begin
    mst.a_ready = '0;
    if (a_hs) mst.a_ready[winner] = 1'b1;
  end

  // D routing: only sources that name a master with a pending request.
  always_comb begin
    d_routed     = 1'b0;
    d_sel        = '0;
    mst.d_valid  = '0;
    mst.d_opcode = '0;
    mst.d_param  = '0;
    mst.d_size   = '0;
    mst.d_source = '0;
    mst.d_sink   = '0;
    mst.d_data   = '0;
    mst.d_error  = '0;
    slv.d_ready  = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (slv.d_source == SRC_WIDTH'(i) && pending_q[i]) begin
        d_routed = 1'b1;
        d_sel    = GW'(i);
        mst.d_valid[i]                              = slv.d_valid;
        mst.d_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH] = slv.d_opcode;
        mst.d_param[i*PARAM_WIDTH +: PARAM_WIDTH]    = slv.d_param;
        mst.d_size[i*SIZE_WIDTH +: SIZE_WIDTH]       = slv.d_size;
        mst.d_source[i*SRC_WIDTH +: SRC_WIDTH]       = src_tbl_q[i];
        mst.d_sink[i*SINK_WIDTH +: SINK_WIDTH]       = slv.d_sink;
        mst.d_data[i*DATA_WIDTH +: DATA_WIDTH]       = slv.d_data;
        mst.d_error[i]                              = slv.d_error;
        slv.d_ready                                 = mst.d_ready[i];
      end
    end
  end

  assign d_hs = d_routed && slv.d_valid && mst.d_ready[d_sel];

  // Next-state and register updates. The D clear and A set never hit the same
  // master in one cycle because a pending master is never eligible.
  always_comb begin
    int w;
    w              = int'(winner);
    state_d        = state_q;
    pending_d      = pending_q;
    last_grant_d   = last_grant_q;
    src_tbl_d      = src_tbl_q;
    a_opcode_d     = a_opcode_q;
    a_param_d      = a_param_q;
    a_size_d       = a_size_q;
    a_source_d     = a_source_q;
    a_address_d    = a_address_q;
    a_mask_d       = a_mask_q;
    a_data_d       = a_data_q;
    d_unexpected_d = slv.d_valid && !d_routed;

    if (d_hs) pending_d[d_sel] = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_hs) begin
          state_d           = SEND;
          pending_d[winner] = 1'b1;
          last_grant_d      = winner;
          src_tbl_d[w]      = mst.a_source[w*SRC_WIDTH +: SRC_WIDTH];
          a_opcode_d        = mst.a_opcode[w*OPCODE_WIDTH +: OPCODE_WIDTH];
          a_param_d         = mst.a_param[w*PARAM_WIDTH +: PARAM_WIDTH];
          a_size_d          = mst.a_size[w*SIZE_WIDTH +: SIZE_WIDTH];
          a_source_d        = SRC_WIDTH'(w);
          a_address_d       = mst.a_address[w*ADDR_WIDTH +: ADDR_WIDTH];
          a_mask_d          = mst.a_mask[w*MASK_WIDTH +: MASK_WIDTH];
          a_data_d          = mst.a_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      SEND: begin
        if (slv.a_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      last_grant_q   <= GW'(NUM_MASTERS - 1);
      for (int i = 0; i < NUM_MASTERS; i++) src_tbl_q[i] <= '0;
      a_opcode_q     <= '0;
      a_param_q      <= '0;
      a_size_q       <= '0;
      a_source_q     <= '0;
      a_address_q    <= '0;
      a_mask_q       <= '0;
      a_data_q       <= '0;
      d_unexpected_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      last_grant_q   <= last_grant_d;
      src_tbl_q      <= src_tbl_d;
      a_opcode_q     <= a_opcode_d;
      a_param_q      <= a_param_d;
      a_size_q       <= a_size_d;
      a_source_q     <= a_source_d;
      a_address_q    <= a_address_d;
      a_mask_q       <= a_mask_d;
      a_data_q       <= a_data_d;
      d_unexpected_q <= d_unexpected_d;
    end
  end

  assign slv.a_valid   = (state_q == SEND);
  assign slv.a_opcode  = a_opcode_q;
  assign slv.a_param   = a_param_q;
  assign slv.a_size    = a_size_q;
  assign slv.a_source  = a_source_q;
  assign slv.a_address = a_address_q;
  assign slv.a_mask    = a_mask_q;
  assign slv.a_data    = a_data_q;
  assign d_unexpected  = d_unexpected_q;
endmodule

// File: tb/tb_tlul_a_arbiter.sv
module tb_tlul_a_arbiter;
  logic clk_100 = 1'b0;
  logic reset_n = 1'b0;
  logic d_unexpected;

  always #5 clk_100 = ~clk_100;

  tlul_a_arbiter_if #(.N(3)) mif ();
  tlul_a_arbiter_if #(.N(1)) sif ();

  tlul_a_arbiter #(.NUM_MASTERS(3)) dut (
    .clk_100      (clk_100),
    .reset_n      (reset_n),
    .mst          (mif),
    .slv          (sif),
    .d_unexpected (d_unexpected)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  av;
    logic        ar;
    logic        dv;
    logic [1:0]  ds;
    logic [2:0]  dr;
    logic [2:0]  e_ardy;
    logic        e_sav;
    logic [1:0]  e_ssrc;
    logic [31:0] e_saddr;
    logic [2:0]  e_mdv;
    logic        e_sdr;
    logic        e_unexp;
    logic [5:0]  e_mdsrc;
    int          e_sel;   // routed master index, 3 = none
  } vec_t;

  function automatic vec_t mk(input logic [2:0] av, input logic ar, input logic dv,
                              input logic [1:0] ds, input logic [2:0] dr,
                              input logic [2:0] ardy, input logic sav, input logic [1:0] ssrc,
                              input logic [31:0] saddr, input logic [2:0] mdv, input logic sdr,
                              input logic unexp, input logic [5:0] mdsrc, input int sel);
    vec_t v;
    v.av = av; v.ar = ar; v.dv = dv; v.ds = ds; v.dr = dr;
    v.e_ardy = ardy; v.e_sav = sav; v.e_ssrc = ssrc; v.e_saddr = saddr;
    v.e_mdv = mdv; v.e_sdr = sdr; v.e_unexp = unexp; v.e_mdsrc = mdsrc; v.e_sel = sel;
    return v;
  endfunction

  function automatic logic [95:0] exp_mdd(input int sel);
    logic [95:0] e;
    e = '0;
    if (sel < 3) e[sel*32 +: 32] = 32'h1234_5678;
    return e;
  endfunction

  vec_t tbl [20];

  initial begin
    // Master payloads: master i at 0x1000*(i+1); master 2 uses source ID 3.
    mif.a_valid   = '0;
    mif.a_opcode  = '0;
    mif.a_param   = '0;
    mif.a_size    = {3'd2, 3'd2, 3'd2};
    mif.a_source  = {2'd3, 2'd1, 2'd0};
    mif.a_address = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    mif.a_mask    = {4'hF, 4'hF, 4'hF};
    mif.a_data    = {32'h2222_2222, 32'h1111_1111, 32'hA5A5_A5A5};
    mif.d_ready   = 3'b111;
    sif.a_ready   = 1'b0;
    sif.d_valid   = 1'b0;
    sif.d_opcode  = 3'd1;
    sif.d_param   = '0;
    sif.d_size    = 3'd2;
    sif.d_source  = '0;
    sif.d_sink    = '0;
    sif.d_data    = 32'h1234_5678;
    sif.d_error   = 1'b0;

    //            av     ar   dv   ds    dr   | ardy  sav  ssrc saddr          mdv   sdr  unx  mdsrc  sel
    tbl[0]  = mk(3'b000,1'b0,1'b0,2'd0,3'b111, 3'b000,1'b0,2'd0,32'h0,        3'b000,1'b1,1'b0,6'h00,3);
    tbl[1]  = mk(3'b001,1'b1,1'b0,2'd0,3'b111, 3'b001,1'b0,2'd0,32'h0,        3'b000,1'b1,1'b0,6'h00,3);
    tbl[2]  = mk(3'b000,1'b1,1'b0,2'd0,3'b111, 3'b000,1'b1,2'd0,32'h1000,     3'b000,1'b1,1'b0,6'h00,0);
    tbl[3]  = mk(3'b000,1'b0,1'b1,2'd0,3'b111, 3'b000,1'b0,2'd0,32'h1000,     3'b001,1'b1,1'b0,6'h00,0);
    tbl[4]  = mk(3'b111,1'b1,1'b0,2'd0,3'b111, 3'b010,1'b0,2'd0,32'h1000,     3'b000,1'b1,1'b0,6'h00,3);
    tbl[5]  = mk(3'b111,1'b1,1'b0,2'd1,3'b111, 3'b000,1'b1,2'd1,32'h2000,     3'b000,1'b1,1'b0,6'h04,1);
    tbl[6]  = mk(3'b111,1'b1,1'b1,2'd1,3'b111, 3'b100,1'b0,2'd1,32'h2000,     3'b010,1'b1,1'b0,6'h04,1);
    tbl[7]  = mk(3'b111,1'b1,1'b1,2'd2,3'b111, 3'b000,1'b1,2'd2,32'h3000,     3'b100,1'b1,1'b0,6'h30,2);
    tbl[8]  = mk(3'b111,1'b0,1'b0,2'd0,3'b111, 3'b001,1'b0,2'd2,32'h3000,     3'b000,1'b1,1'b0,6'h00,3);
    tbl[9]  = mk(3'b111,1'b0,1'b0,2'd0,3'b110, 3'b000,1'b1,2'd0,32'h1000,     3'b000,1'b0,1'b0,6'h00,0);
    tbl[10] = mk(3'b111,1'b0,1'b0,2'd0,3'b110, 3'b000,1'b1,2'd0,32'h1000,     3'b000,1'b0,1'b0,6'h00,0);
    tbl[11] = mk(3'b111,1'b0,1'b0,2'd0,3'b110, 3'b000,1'b1,2'd0,32'h1000,     3'b000,1'b0,1'b0,6'h00,0);
    tbl[12] = mk(3'b111,1'b1,1'b0,2'd0,3'b111, 3'b000,1'b1,2'd0,32'h1000,     3'b000,1'b1,1'b0,6'h00,0);
    tbl[13] = mk(3'b111,1'b0,1'b1,2'd3,3'b111, 3'b010,1'b0,2'd0,32'h1000,     3'b000,1'b1,1'b0,6'h00,3);
    tbl[14] = mk(3'b111,1'b1,1'b0,2'd0,3'b111, 3'b000,1'b1,2'd1,32'h2000,     3'b000,1'b1,1'b1,6'h00,0);
    tbl[15] = mk(3'b111,1'b1,1'b0,2'd0,3'b111, 3'b100,1'b0,2'd1,32'h2000,     3'b000,1'b1,1'b0,6'h00,0);
    tbl[16] = mk(3'b111,1'b1,1'b0,2'd0,3'b111, 3'b000,1'b1,2'd2,32'h3000,     3'b000,1'b1,1'b0,6'h00,0);
    tbl[17] = mk(3'b111,1'b1,1'b0,2'd0,3'b111, 3'b000,1'b0,2'd2,32'h3000,     3'b000,1'b1,1'b0,6'h00,0);
    tbl[18] = mk(3'b111,1'b0,1'b1,2'd1,3'b111, 3'b000,1'b0,2'd2,32'h3000,     3'b010,1'b1,1'b0,6'h04,1);
    tbl[19] = mk(3'b111,1'b1,1'b0,2'd0,3'b111, 3'b010,1'b0,2'd2,32'h3000,     3'b000,1'b1,1'b0,6'h00,0);

    // Reset state
    #7;
    chk("rst_sav",   128'(sif.a_valid),   128'(0));
    chk("rst_saddr", 128'(sif.a_address), 128'(0));
    chk("rst_ssrc",  128'(sif.a_source),  128'(0));
    chk("rst_ardy",  128'(mif.a_ready),   128'(0));
    chk("rst_mdv",   128'(mif.d_valid),   128'(0));
    chk("rst_unexp", 128'(d_unexpected),  128'(0));
    @(negedge clk_100);
    @(negedge clk_100);
    reset_n = 1'b1;

    // Cycle-by-cycle vector table
    for (int r = 0; r < 20; r++) begin
      @(negedge clk_100);
      mif.a_valid  = tbl[r].av;
      sif.a_ready  = tbl[r].ar;
      sif.d_valid  = tbl[r].dv;
      sif.d_source = tbl[r].ds;
      mif.d_ready  = tbl[r].dr;
      #2;
      chk($sformatf("r%0d_ardy", r),  128'(mif.a_ready),   128'(tbl[r].e_ardy));
      chk($sformatf("r%0d_sav", r),   128'(sif.a_valid),   128'(tbl[r].e_sav));
      chk($sformatf("r%0d_ssrc", r),  128'(sif.a_source),  128'(tbl[r].e_ssrc));
      chk($sformatf("r%0d_saddr", r), 128'(sif.a_address), 128'(tbl[r].e_saddr));
      chk($sformatf("r%0d_mdv", r),   128'(mif.d_valid),   128'(tbl[r].e_mdv));
      chk($sformatf("r%0d_sdr", r),   128'(sif.d_ready),   128'(tbl[r].e_sdr));
      chk($sformatf("r%0d_unexp", r), 128'(d_unexpected),  128'(tbl[r].e_unexp));
      chk($sformatf("r%0d_mdsrc", r), 128'(mif.d_source),  128'(tbl[r].e_mdsrc));
      chk($sformatf("r%0d_mdd", r),   128'(mif.d_data),    128'(exp_mdd(tbl[r].e_sel)));
    end

    // Long backpressure on master 1's request: payload must hold.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_100);
      mif.a_valid = 3'b111; sif.a_ready = 1'b0; sif.d_valid = 1'b0; sif.d_source = 2'd0;
      #2;
      chk($sformatf("bp%0d_sav", c),   128'(sif.a_valid),   128'(1));
      chk($sformatf("bp%0d_saddr", c), 128'(sif.a_address), 128'(32'h2000));
      chk($sformatf("bp%0d_sdata", c), 128'(sif.a_data),    128'(32'h1111_1111));
      chk($sformatf("bp%0d_ardy", c),  128'(mif.a_ready),   128'(0));
    end
    @(negedge clk_100);
    sif.a_ready = 1'b1;
    #2;
    chk("bp_rel_sav", 128'(sif.a_valid), 128'(1));
    @(negedge clk_100);
    sif.a_ready = 1'b0;
    #2;
    chk("bp_done_sav",  128'(sif.a_valid), 128'(0));
    chk("bp_done_ardy", 128'(mif.a_ready), 128'(0));

    // Respond to master 2 (source restored to 3), then re-grant it.
    @(negedge clk_100);
    sif.d_valid = 1'b1; sif.d_source = 2'd2;
    #2;
    chk("m2rsp_mdv",   128'(mif.d_valid),       128'(3'b100));
    chk("m2rsp_mdsrc", 128'(mif.d_source[5:4]), 128'(2'd3));
    @(negedge clk_100);
    sif.d_valid = 1'b0; sif.d_source = 2'd0; mif.a_valid = 3'b100;
    #2;
    chk("m2regrant_ardy", 128'(mif.a_ready), 128'(3'b100));
    @(negedge clk_100);
    mif.a_valid = 3'b000;
    #2;
    chk("m2send_sav",  128'(sif.a_valid),   128'(1));
    chk("m2send_ssrc", 128'(sif.a_source),  128'(2));

    // Asynchronous reset in the middle of SEND.
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_sav",   128'(sif.a_valid),   128'(0));
    chk("arst_saddr", 128'(sif.a_address), 128'(0));
    chk("arst_ardy",  128'(mif.a_ready),   128'(0));
    @(negedge clk_100);
    reset_n = 1'b1;
    sif.d_valid = 1'b1; sif.d_source = 2'd2; mif.d_ready = 3'b000;
    #2;
    chk("stale_sdr", 128'(sif.d_ready), 128'(1));
    chk("stale_mdv", 128'(mif.d_valid), 128'(0));
    @(negedge clk_100);
    sif.d_valid = 1'b0; mif.d_ready = 3'b111; mif.a_valid = 3'b111;
    #2;
    chk("stale_unexp", 128'(d_unexpected), 128'(1));
    chk("post_rst_ardy", 128'(mif.a_ready), 128'(3'b001));
    @(negedge clk_100);
    mif.a_valid = 3'b000;
    #2;
    chk("unexp_once",   128'(d_unexpected),  128'(0));
    chk("post_rst_sav", 128'(sif.a_valid),   128'(1));
    chk("post_rst_addr",128'(sif.a_address), 128'(32'h1000));
    chk("post_rst_data",128'(sif.a_data),    128'(32'hA5A5_A5A5));
    chk("post_rst_opc", 128'(sif.a_opcode),  128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlul_a_arbiter.md
# tlul_a_arbiter

Round-robin TL-UL arbiter that shares the single slave port of the TL-UL interconnect among `NUM_MASTERS` masters. Accepts one A-channel request at a time into a registered output stage, forwards it to the slave with the master index as `a_source`, and routes D-channel responses back to the issuing master by source while restoring the master's original source ID. Enforces at most one outstanding request per master. Sits in the interconnect between the per-master A/D ports and the slave port, in the `clk_100` domain.

## Interface
- `NUM_MASTERS`, 3, requesters; must satisfy `NUM_MASTERS <= 2**SRC_WIDTH`
- `OPCODE_WIDTH`, 3, A/D opcode width
- `PARAM_WIDTH`, 3, param width
- `SIZE_WIDTH`, 3, size width
- `SRC_WIDTH`, 2, source ID width (master and slave side)
- `SINK_WIDTH`, 1, sink width
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `MASK_WIDTH`, `DATA_WIDTH/8`, byte mask width
- `clk_100`  in  1  sole clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `master_a_valid`/`master_a_ready`  in/out  `NUM_MASTERS`  per-master A handshake
- `master_a_opcode`, `_param`, `_size`, `_source`, `_address`, `_mask`, `_data`  in  `NUM_MASTERS*`field width  flattened A payloads; master i at `[i*W +: W]`
- `master_d_valid`/`master_d_ready`  out/in  `NUM_MASTERS`  per-master D handshake
- `master_d_opcode`, `_param`, `_size`, `_source`, `_sink`, `_data`  out  `NUM_MASTERS*`field width  flattened D payloads
- `master_d_error`  out  `NUM_MASTERS`  per-master D error
- `slave_a_valid`/`slave_a_ready`  out/in  1  slave A handshake
- `slave_a_opcode`..`slave_a_data`  out  field widths  registered A payload
- `slave_d_valid`/`slave_d_ready`  in/out  1  slave D handshake
- `slave_d_opcode`..`slave_d_data`, `slave_d_error`  in  field widths  slave D payload
- `d_unexpected`  out  1  one-cycle pulse: D beat dropped (unroutable)

## Operation
- FSM states: IDLE, SEND.
- IDLE: eligible[i] = `master_a_valid[i] & ~pending[i]`. Round-robin pick starting at `(last_grant+1) mod NUM_MASTERS`. `master_a_ready[winner]` = 1 combinationally in IDLE only; all other `master_a_ready` = 0. On the handshake edge: latch winner's opcode/param/size/address/mask/data into output register, set `slave_a_source` = winner index, store master's `a_source` in `src_tbl[winner]`, set `pending[winner]`, `last_grant <= winner`, go to SEND. No eligible master: stay IDLE.
- SEND: `slave_a_valid` = 1, payload held stable. On `slave_a_ready` edge go to IDLE. Payload may change only in IDLE.
- D path (combinational, independent of FSM): idx = `slave_d_source`. If idx < `NUM_MASTERS` and `pending[idx]`: `master_d_valid[idx]` = `slave_d_valid`, payload copied to slice idx, `master_d_source[idx]` = `src_tbl[idx]`, `slave_d_ready` = `master_d_ready[idx]`; on handshake clear `pending[idx]`. Otherwise `slave_d_ready` = 1, no `master_d_valid`, `d_unexpected` pulses (registered) the cycle after the dropped beat.
- Non-selected `master_d_*` slices drive 0.

## Timing
- Reset (async assert, sync-safe release): state IDLE, `pending` = 0, `last_grant` = `NUM_MASTERS-1` (master 0 wins first), `src_tbl` = 0, `slave_a_valid` = 0, slave A payload = 0, `d_unexpected` = 0, all `master_a_ready` = 0, `master_d_valid` = 0.
- Latency: master handshake at edge N -> `slave_a_valid` high from cycle N+1; max A throughput one request per 2 cycles.
- Same master not re-granted until its D handshake; eligibility uses registered `pending`, so D handshake at edge N permits grant from cycle N+1 onward.
- D handshake for master i and A grant for master j≠i in same cycle: both take effect.
- Reset mid-SEND: request discarded, `slave_a_valid` drops immediately; outstanding responses after reset arrive as unexpected and are dropped.
- Masters must hold A payload stable while valid and not ready (TL-UL rule); arbiter samples only on handshake edge.

## Test plan
- Single Put: master 0 Put (opcode 0) addr 0x1000 data 0xA5A5A5A5 source 0, slave_a_ready=1 -> `master_a_ready[0]` in IDLE, `slave_a_valid` next cycle with addr 0x1000, `slave_a_source`=0; slave D AccessAck source 0 -> `master_d_valid[0]`, `master_d_source[0]`=0.
- Round-robin: masters 0,1,2 all valid from reset, slave ready, responses returned promptly -> grant order 0,1,2,0; `slave_a_address` matches each master.
- Backpressure: slave_a_ready=0 for 10 cycles during SEND -> payload stable, no new `master_a_ready`; ready=1 -> single slave handshake.
- Outstanding block: master 1 granted, no D response, master 1 revalid -> never granted while master 2 requests are served; D AccessAckData source 1 data 0x12345678 -> delivered, master 1 granted next IDLE.
- Source restore / drop: master 2 sends source 3 -> `slave_a_source`=2, response returns `master_d_source[2]`=3; slave D with source 3 -> `slave_d_ready`=1, `d_unexpected` pulses once, no master D valid.
- Async reset asserted mid-SEND -> `slave_a_valid` 0 immediately, `pending` cleared, master 0 wins first after release.
